// File: rtl/mem_port_arbiter_pkg.sv
// ============================================================================
// Module      : mips_arb_pkg
// Description : Shared types and default widths for the memory port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_arb_pkg;

  localparam int C_ADDR_W       = 32;
  localparam int C_DATA_W       = 32;
  localparam int C_MAX_D_STREAK = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } arb_owner_t;

endpackage

`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
// ============================================================================
// Module      : mem_port_arbiter_if
// Description : Fetch, data and memory-side signals of the memory port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_port_arbiter_if
  import mips_arb_pkg::*;
#(
  parameter int ADDR_W = C_ADDR_W,
  parameter int DATA_W = C_DATA_W
) ();

  logic              ifReq;
  logic [ADDR_W-1:0] ifAddr;
  logic              ifDone;
  logic [DATA_W-1:0] ifRdata;
  logic              dReq;
  logic              dWe;
  logic [ADDR_W-1:0] dAddr;
  logic [DATA_W-1:0] dWdata;
  logic              dDone;
  logic [DATA_W-1:0] dRdata;
  logic              memReq;
  logic              memWe;
  logic [ADDR_W-1:0] memAddr;
  logic [DATA_W-1:0] memWdata;
  logic [DATA_W-1:0] memRdata;
  logic              memAck;
  logic              stallIF;
  logic              stallPipe;

  // Arbiter side
  modport slave (
    input  ifReq, ifAddr, dReq, dWe, dAddr, dWdata, memRdata, memAck,
    output ifDone, ifRdata, dDone, dRdata, memReq, memWe, memAddr, memWdata,
    output stallIF, stallPipe
  );

  // Requester / memory side
  modport master (
    output ifReq, ifAddr, dReq, dWe, dAddr, dWdata, memRdata, memAck,
    input  ifDone, ifRdata, dDone, dRdata, memReq, memWe, memAddr, memWdata,
    input  stallIF, stallPipe
  );

endinterface

`default_nettype wire

// File: rtl/mem_port_arbiter_streak.sv
// ============================================================================
// Module      : arb_streak_counter
// Description : Saturating count of consecutive data grants made while a
//               fetch was waiting.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module arb_streak_counter #(
  parameter int MAX_COUNT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_sat
);

  localparam int                CNT_W = $clog2(MAX_COUNT + 1);
  localparam logic [CNT_W-1:0]  c_max = CNT_W'(MAX_COUNT);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != c_max)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_sat = (r_count == c_max);

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one variable-latency memory port between instruction
//               fetch and data accesses; data has priority with a fetch
//               anti-starvation guard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter
  import mips_arb_pkg::*;
#(
  parameter int ADDR_W       = C_ADDR_W,
  parameter int DATA_W       = C_DATA_W,
  parameter int MAX_D_STREAK = C_MAX_D_STREAK
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus
);

  arb_state_t        r_state;
  arb_owner_t        r_owner;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_if_done;
  logic              r_d_done;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_d_rdata;

  logic w_idle;
  logic w_sat;
  logic w_grant_d;
  logic w_grant_if;
  logic w_streak_inc;
  logic w_streak_clr;

  // Data wins unless fetch has already waited out a full streak.
  assign w_idle       = (r_state == IDLE);
  assign w_grant_d    = w_idle & bus.dReq & ~(bus.ifReq & w_sat);
  assign w_grant_if   = w_idle & bus.ifReq & ~w_grant_d;
  assign w_streak_inc = w_grant_d & bus.ifReq;
  assign w_streak_clr = w_grant_if | (w_idle & ~bus.ifReq);

  arb_streak_counter #(
    .MAX_COUNT (MAX_D_STREAK)
  ) u_streak (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_streak_inc),
    .i_clr (w_streak_clr),
    .o_sat (w_sat)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_owner     <= OWN_NONE;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_done   <= 1'b0;
      r_d_done    <= 1'b0;
      r_if_rdata  <= '0;
      r_d_rdata   <= '0;
    end else begin
      r_if_done <= 1'b0;
      r_d_done  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_grant_d) begin
            r_state     <= BUSY;
            r_owner     <= OWN_D;
            r_mem_req   <= 1'b1;
            r_mem_we    <= bus.dWe;
            r_mem_addr  <= bus.dAddr;
            r_mem_wdata <= bus.dWdata;
          end else if (w_grant_if) begin
            r_state     <= BUSY;
            r_owner     <= OWN_IF;
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= bus.ifAddr;
            r_mem_wdata <= '0;
          end
        end
        BUSY: begin
          if (bus.memAck) begin
            r_state   <= DONE;
            r_mem_req <= 1'b0;
            if (r_owner == OWN_IF) begin
              r_if_done  <= 1'b1;
              r_if_rdata <= bus.memRdata;
            end else begin
              r_d_done <= 1'b1;
              if (!r_mem_we) begin
                r_d_rdata <= bus.memRdata;
              end
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_owner <= OWN_NONE;
        end
        default: begin
          r_state   <= IDLE;
          r_owner   <= OWN_NONE;
          r_mem_req <= 1'b0;
        end
      endcase
    end
  end

  assign bus.memReq    = r_mem_req;
  assign bus.memWe     = r_mem_we;
  assign bus.memAddr   = r_mem_addr;
  assign bus.memWdata  = r_mem_wdata;
  assign bus.ifDone    = r_if_done;
  assign bus.dDone     = r_d_done;
  assign bus.ifRdata   = r_if_rdata;
  assign bus.dRdata    = r_d_rdata;
  assign bus.stallIF   = bus.ifReq & ~r_if_done;
  assign bus.stallPipe = bus.dReq & ~r_d_done;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Self-checking bench for mem_port_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(
    .ADDR_W       (32),
    .DATA_W       (32),
    .MAX_D_STREAK (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        is_d;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          delay;
    logic [31:0] rdata;
    logic        exp_we;
    logic [31:0] exp_if_rdata;
    logic [31:0] exp_d_rdata;
  } vec_t;

  vec_t vecs [5];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_memreq(input string name);
    int waited = 0;
    while (!bus.memReq && waited < 20) begin
      step();
      waited++;
    end
    chk(name, bus.memReq, 1'b1);
  endtask

  task automatic run_vec(input vec_t v);
    if (v.is_d) begin
      bus.dReq = 1'b1; bus.dWe = v.we; bus.dAddr = v.addr; bus.dWdata = v.wdata;
    end else begin
      bus.ifReq = 1'b1; bus.ifAddr = v.addr;
    end
    step();
    chk("grant_latency", bus.memReq, 1'b1);
    wait_memreq("grant_timeout");
    chk("mem_addr", bus.memAddr, v.addr);
    chk("mem_we", bus.memWe, v.exp_we);
    if (v.exp_we) chk("mem_wdata", bus.memWdata, v.wdata);
    chk("stall_busy", v.is_d ? bus.stallPipe : bus.stallIF, 1'b1);
    repeat (v.delay) step();
    chk("memreq_held", bus.memReq, 1'b1);
    bus.memAck = 1'b1; bus.memRdata = v.rdata;
    step();
    bus.memAck = 1'b0;
    chk("if_done", bus.ifDone, !v.is_d);
    chk("d_done", bus.dDone, v.is_d);
    chk("if_rdata", bus.ifRdata, v.exp_if_rdata);
    chk("d_rdata", bus.dRdata, v.exp_d_rdata);
    chk("stall_done", v.is_d ? bus.stallPipe : bus.stallIF, 1'b0);
    chk("memreq_drop", bus.memReq, 1'b0);
    bus.ifReq = 1'b0; bus.dReq = 1'b0;
    step();
    chk("done_once", {bus.ifDone, bus.dDone}, 2'b00);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        exp_d [10];
    logic [31:0] b2b_rd [3];
    int          age, k, last, rises;
    logic        prev_req;

    vecs[0] = '{1'b0, 1'b0, 32'h40,  32'h0,        2, 32'h8C010004, 1'b0, 32'h8C010004, 32'h0};
    vecs[1] = '{1'b1, 1'b1, 32'h100, 32'hDEADBEEF, 1, 32'h12345678, 1'b1, 32'h8C010004, 32'h0};
    vecs[2] = '{1'b1, 1'b0, 32'h200, 32'h11111111, 1, 32'hCAFEF00D, 1'b0, 32'h8C010004, 32'hCAFEF00D};
    vecs[3] = '{1'b0, 1'b0, 32'h44,  32'h0,        3, 32'h20420001, 1'b0, 32'h20420001, 32'hCAFEF00D};
    vecs[4] = '{1'b1, 1'b1, 32'h204, 32'h0BADF00D, 2, 32'hFFFFFFFF, 1'b1, 32'h20420001, 32'hCAFEF00D};
    exp_d  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    b2b_rd = '{32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2};

    bus.ifReq = 0; bus.ifAddr = 0; bus.dReq = 0; bus.dWe = 0; bus.dAddr = 0;
    bus.dWdata = 0; bus.memAck = 0; bus.memRdata = 0;
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    step();
    chk("rst_outputs", {bus.memReq, bus.memWe, bus.ifDone, bus.dDone, bus.stallIF, bus.stallPipe}, 6'b0);
    chk("rst_addr_wdata", {bus.memAddr, bus.memWdata}, 64'h0);
    chk("rst_rdata", {bus.ifRdata, bus.dRdata}, 64'h0);

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Both requesters held: D four times, then fetch forced, then again.
    bus.ifReq = 1'b1; bus.ifAddr = 32'h80;
    bus.dReq = 1'b1; bus.dWe = 1'b0; bus.dAddr = 32'h300;
    for (int g = 0; g < 10; g++) begin
      step();
      wait_memreq("streak_grant_timeout");
      chk("streak_owner_addr", bus.memAddr, exp_d[g] ? 32'h300 : 32'h80);
      step();
      bus.memAck = 1'b1; bus.memRdata = 32'h1000 + g;
      step();
      bus.memAck = 1'b0;
      chk("streak_d_done", bus.dDone, exp_d[g]);
      chk("streak_if_done", bus.ifDone, !exp_d[g]);
    end
    bus.ifReq = 1'b0; bus.dReq = 1'b0;
    repeat (2) step();

    // Back-to-back loads, ack one cycle after memReq rises.
    age = 0; k = 0; last = -1; rises = 0; prev_req = 1'b0;
    bus.dReq = 1'b1; bus.dWe = 1'b0; bus.dAddr = 32'h500;
    for (int c = 0; c < 40 && k < 3; c++) begin
      step();
      bus.memAck = 1'b0;
      if (bus.memReq && !prev_req) rises++;
      prev_req = bus.memReq;
      if (bus.dDone) begin
        chk("b2b_rdata", bus.dRdata, b2b_rd[k]);
        if (last >= 0) chk("b2b_period", 64'(c - last), 64'd4);
        last = c;
        k++;
        if (k == 3) bus.dReq = 1'b0;
        else bus.dAddr = 32'h500 + 32'(4 * k);
      end
      if (bus.memReq && k < 3) begin
        age++;
        if (age == 1) chk("b2b_addr", bus.memAddr, 32'h500 + 32'(4 * k));
        if (age == 2) begin
          bus.memAck = 1'b1; bus.memRdata = b2b_rd[k];
        end
      end else begin
        age = 0;
      end
    end
    chk("b2b_count", 64'(k), 64'd3);
    repeat (4) begin
      step();
      if (bus.memReq && !prev_req) rises++;
      prev_req = bus.memReq;
    end
    chk("b2b_grants", 64'(rises), 64'd3);

    // Reset in the second BUSY cycle of a load, followed by a stray ack.
    bus.dReq = 1'b1; bus.dWe = 1'b0; bus.dAddr = 32'h400;
    step();
    chk("abort_memreq_up", bus.memReq, 1'b1);
    step();
    rst = 1'b1; bus.dReq = 1'b0;
    step();
    rst = 1'b0;
    chk("abort_memreq_low", bus.memReq, 1'b0);
    chk("abort_no_done", {bus.ifDone, bus.dDone}, 2'b00);
    chk("abort_rdata", {bus.ifRdata, bus.dRdata}, 64'h0);
    bus.memAck = 1'b1; bus.memRdata = 32'h55555555;
    step();
    bus.memAck = 1'b0;
    chk("late_ack_no_done", {bus.ifDone, bus.dDone, bus.memReq}, 3'b000);
    chk("late_ack_rdata", bus.dRdata, 32'h0);

    // Spurious acks while idle.
    bus.memAck = 1'b1; bus.memRdata = 32'h77777777;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("spurious_quiet", {bus.ifDone, bus.dDone, bus.memReq}, 3'b000);
      chk("spurious_rdata", {bus.ifRdata, bus.dRdata}, 64'h0);
    end
    bus.memAck = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
